// File: rtl/chunked_sub_nbit_pkg.sv
// Shared definitions for the chunked subtractor: FSM state encodings and
// default geometry constants.
package chunked_sub_nbit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/chunked_sub_nbit_sub_chunk.sv
// sub_chunk: combinational CHUNK-bit ripple-borrow subtractor slice.
// Computes {bo, d} such that d = x - y - bi (mod 2^CHUNK), bo = final borrow.
module sub_chunk
    import chunked_sub_nbit_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bi,
    output logic [CHUNK-1:0] d,
    output logic             bo
);

    logic [CHUNK:0] br;

    // Ripple the borrow from bit 0 upwards through the slice.
    always_comb begin
        br    = '0;
        d     = '0;
        br[0] = bi;
        for (int i = 0; i < CHUNK; i++) begin
            d[i]    = x[i] ^ y[i] ^ br[i];
            br[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br[i]);
        end
    end

    assign bo = br[CHUNK];

endmodule

// File: rtl/chunked_sub_nbit.sv
// chunked_sub_nbit: multi-cycle subtractor, diff = a - b - bin, resolving
// CHUNK bits per clock from the LSB using one shared sub_chunk slice.
// Optional feature: define SUB_OVF_FLAG_EN to add the signed overflow port ovf.
module chunked_sub_nbit
    import chunked_sub_nbit_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
`ifdef SUB_OVF_FLAG_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic [CHUNK-1:0] chk_d;
    logic             chk_bo;
    logic [WIDTH-1:0] acc_next;

    sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
        .x  (a_sh_q[CHUNK-1:0]),
        .y  (b_sh_q[CHUNK-1:0]),
        .bi (brw_q),
        .d  (chk_d),
        .bo (chk_bo)
    );

    // The newest chunk result enters at the top; after NCHUNK shifts the
    // first chunk has reached bit 0 and the accumulator holds the full diff.
    assign acc_next = (acc_q >> CHUNK) | (WIDTH'(chk_d) << (WIDTH - CHUNK));

    // Next-state, datapath sequencing and result capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        brw_d   = brw_q;
        acc_d   = acc_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SUB_OVF_FLAG_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bin;
                    cnt_d   = '0;
                    acc_d   = '0;
`ifdef SUB_OVF_FLAG_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> CHUNK;
                b_sh_d = b_sh_q >> CHUNK;
                brw_d  = chk_bo;
                acc_d  = acc_next;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    diff_d  = acc_next;
                    bout_d  = chk_bo;
`ifdef SUB_OVF_FLAG_EN
                    ovf_d   = (a_msb_q != b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
`endif
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            brw_q   <= 1'b0;
            acc_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            brw_q   <= brw_d;
            acc_q   <= acc_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SUB_OVF_FLAG_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);
    assign diff = diff_q;
    assign bout = bout_q;
`ifdef SUB_OVF_FLAG_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_chunked_sub_nbit.sv
// Bench for chunked_sub_nbit (32-bit, 4-bit chunks). Build with
// SUB_OVF_FLAG_EN defined to also exercise the ovf port.
module tb_chunked_sub_nbit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic        busy;
    logic        done;
    logic [31:0] diff;
    logic        bout;
    logic        ovf_s;

    int total = 0;
    int bad   = 0;

    chunked_sub_nbit #(.WIDTH(32), .CHUNK(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_OVF_FLAG_EN
        ,
        .ovf   (ovf_s)
`endif
    );

`ifndef SUB_OVF_FLAG_EN
    assign ovf_s = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;
        logic        bo;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference: subtraction in 33-bit plain arithmetic; bit 32 is the borrow.
    function automatic logic [32:0] ref_sub(input logic [31:0] x, input logic [31:0] y, input logic bi);
        return {1'b0, x} - {1'b0, y} - 33'(bi);
    endfunction

    function automatic logic ref_ovf(input logic [31:0] x, input logic [31:0] y, input logic [31:0] d);
        return (x[31] != y[31]) && (d[31] != x[31]);
    endfunction

    // Launch one operation; returns at the negedge where done is seen, or on timeout.
    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic ibin,
                          output int edges, output logic timed_out);
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; bin = ibin;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        timed_out = !done;
    endtask

    task automatic wait_done(output logic timed_out);
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        timed_out = !done;
    endtask

    initial begin
        int          edges;
        logic        to;
        logic [31:0] held;
        logic [32:0] r;
        int          dcount;

        vecs[0] = '{"t1_5m2",      32'h5,        32'h2,        1'b0, 32'h3,        1'b0};
        vecs[1] = '{"t2_0m1",      32'h0,        32'h1,        1'b0, 32'hFFFFFFFF, 1'b1};
        vecs[2] = '{"t3_carry",    32'h10000FFF, 32'h0000FFFF, 1'b0, 32'h0FFF1000, 1'b0};
        vecs[3] = '{"t4_bin",      32'h8,        32'h5,        1'b1, 32'h2,        1'b0};
        vecs[4] = '{"eq_zero",     32'h12345678, 32'h12345678, 1'b0, 32'h0,        1'b0};
        vecs[5] = '{"0m0_bin",     32'h0,        32'h0,        1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[6] = '{"max_max_bin", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[7] = '{"max_0_bin",   32'hFFFFFFFF, 32'h0,        1'b1, 32'hFFFFFFFE, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", diff, 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ovf",  32'(ovf_s), 32'd0);
        rst = 1'b0;

        // Table-driven vectors, with latency and one-cycle done pulse.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, edges, to);
            chk({vecs[i].name, "_timeout"}, 32'(to), 32'd0);
            chk({vecs[i].name, "_lat"}, 32'(edges), 32'd9);
            chk({vecs[i].name, "_diff"}, diff, vecs[i].d);
            chk({vecs[i].name, "_bout"}, 32'(bout), 32'(vecs[i].bo));
            held = diff;
            @(posedge clk); @(negedge clk);
            chk({vecs[i].name, "_done_drop"}, 32'(done), 32'd0);
            chk({vecs[i].name, "_busy_drop"}, 32'(busy), 32'd0);
            chk({vecs[i].name, "_hold"}, diff, held);
        end

        // Start pulsed during RUN cycle 3 must be ignored.
        @(negedge clk);
        start = 1'b1; a = 32'h8; b = 32'h5; bin = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        start = 1'b1; a = 32'h9;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        wait_done(to);
        chk("busy_start_timeout", 32'(to), 32'd0);
        chk("busy_start_diff", diff, 32'h2);
        chk("busy_start_bout", 32'(bout), 32'd0);
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("busy_start_noqueue", 32'(busy), 32'd0);
        chk("busy_start_hold", diff, 32'h2);

        // Reset at RUN cycle 4 aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; a = 32'hDEADBEEF; b = 32'h1; bin = 1'b0;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_diff", diff, 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        dcount = 0;
        repeat (12) begin
            @(posedge clk); @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);
        run_op(32'h7, 32'h7, 1'b0, edges, to);
        chk("after_abort_timeout", 32'(to), 32'd0);
        chk("after_abort_diff", diff, 32'd0);
        chk("after_abort_bout", 32'(bout), 32'd0);
        @(posedge clk); @(negedge clk);

        // Simultaneous rst and start: start is dropped.
        rst = 1'b1; start = 1'b1; a = 32'h5; b = 32'h2; bin = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'd0);
        repeat (2) begin @(posedge clk); @(negedge clk); end
        chk("rst_start_idle", 32'(busy), 32'd0);

`ifdef SUB_OVF_FLAG_EN
        run_op(32'h80000000, 32'h1, 1'b0, edges, to);
        chk("ovf1_diff", diff, 32'h7FFFFFFF);
        chk("ovf1_ovf", 32'(ovf_s), 32'd1);
        chk("ovf1_bout", 32'(bout), 32'd0);
        @(posedge clk); @(negedge clk);
        run_op(32'h3, 32'h1, 1'b0, edges, to);
        chk("ovf0_diff", diff, 32'h2);
        chk("ovf0_ovf", 32'(ovf_s), 32'd0);
        @(posedge clk); @(negedge clk);
`endif

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            logic        rbi;
            ra  = $urandom;
            rb  = (i % 5 == 0) ? ra : $urandom;
            if (i % 7 == 3) rb = ra + 32'd1;
            rbi = 1'($urandom_range(0, 1));
            r   = ref_sub(ra, rb, rbi);
            run_op(ra, rb, rbi, edges, to);
            chk("rnd_timeout", 32'(to), 32'd0);
            chk("rnd_diff", diff, r[31:0]);
            chk("rnd_bout", 32'(bout), 32'(r[32]));
`ifdef SUB_OVF_FLAG_EN
            chk("rnd_ovf", 32'(ovf_s), 32'(ref_ovf(ra, rb, r[31:0])));
`endif
            @(posedge clk); @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
